invert_pose: RTL
================

INVERT_POSE -- requirements
Module: invert_pose

Interface
REQ-001 SHALL have parameter MUL_STAGES, default 2: pipeline depth of the time-shared signed multiplier.
REQ-002 SHALL take POSE_BW (word width) and MUL (fractional bits, 24 => 1.0 = 16777216) from RgbdVoConfigPk.
REQ-003 SHALL have port i_clk, input, 1: the only clock.
REQ-004 SHALL have port i_rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port i_start, input, 1: one-cycle request to invert i_pose.
REQ-006 SHALL have port i_pose[12], input, POSE_BW signed each: row-major 3x4 [R|t], indices 3/7/11 = t.
REQ-007 SHALL have port o_busy, output, 1: high while a computation is in flight.
REQ-008 SHALL have port o_done, output, 1: single-cycle completion pulse.
REQ-009 SHALL have port o_pose[12], output, POSE_BW signed each: inverse pose [R^T | -R^T t].

Function
REQ-010 SHALL implement FSM states IDLE and BUSY: IDLE->BUSY on i_start; BUSY->IDLE in the cycle o_done is high.
REQ-011 SHALL capture all 12 i_pose words on the accepted i_start edge; i_pose is don't-care afterwards.
REQ-012 SHALL ignore i_start while BUSY, except in the o_done cycle, where i_start SHALL be accepted (back-to-back operation).
REQ-013 SHALL write the rotation outputs as direct copies: o[0,1,2]=p[0,4,8], o[4,5,6]=p[1,5,9], o[8,9,10]=p[2,6,10].
REQ-014 SHALL compute o[3]=-(p0*p3+p4*p7+p8*p11), o[7]=-(p1*p3+p5*p7+p9*p11) and o[11]=-(p2*p3+p6*p7+p10*p11) as 9 multiplies through one multiplier, issued one per cycle in that order.
REQ-015 SHALL scale each 2*POSE_BW-bit product by an arithmetic right shift of MUL bits, register it, and accumulate it at 2*POSE_BW-MUL+2 bits.
REQ-016 SHALL negate each final sum and truncate it (two's-complement wrap) to POSE_BW.
REQ-017 SHALL raise o_done exactly 11+MUL_STAGES cycles after the accepted i_start edge (13 at default).
REQ-018 SHALL update all 12 o_pose words in the same cycle o_done rises.
REQ-019 SHALL hold o_pose stable from then until the next completion.
REQ-020 SHALL hold o_busy high from the cycle after the accepted start through the o_done cycle inclusive.

Reset
REQ-021 SHALL, on i_rst_n low (including mid-operation), immediately set FSM=IDLE, counter=0, accumulators=0, o_done=0, o_busy=0 and o_pose=all zero.
REQ-022 SHALL discard any in-flight multiplier result after reset release; no o_done for the aborted operation.

Configuration
REQ-023 With INVERT_POSE_ROUND_EN defined, SHALL add 2^(MUL-1) to each product before the MUL shift (round half up).
REQ-024 Without INVERT_POSE_ROUND_EN, SHALL truncate toward negative infinity, bit-exact with the pose-update block.
REQ-025 Latency SHALL be identical in both builds.

Structure
REQ-026 SHALL take POSE_BW, MUL and a fixed-point ONE constant (1<<MUL) from RgbdVoConfigPk; the 9-step issue schedule and the latency constant belong there too.
REQ-027 SHALL place multiplier + shift register + accumulator in one sub-module, pose_mac; the FSM, counter and operand mux stay in invert_pose.

Verification
REQ-028 Identity (p0=p5=p10=16777216, others 0) -> o_pose identical to input, o_done at cycle 13.
REQ-029 Identity R, t=(16777216, 33554432, -50331648) -> o[3]=-16777216, o[7]=-33554432, o[11]=50331648.
REQ-030 R=90 deg about z (p1=-16777216, p4=16777216, p10=16777216), t=(16777216,0,0) -> o[1]=16777216, o[4]=-16777216, o[3]=0, o[7]=16777216, o[11]=0.
REQ-031 Arithmetic: p0=1, p3=8388608, all else 0 -> o[3]=0 without INVERT_POSE_ROUND_EN; o[3]=-1 with it.
REQ-032 Protocol: i_start pulsed at cycles 5 and 6 -> one o_done; second start in o_done cycle -> next o_done 13 cycles later.
REQ-033 Reset: i_rst_n low at cycle 7 of an operation -> all outputs 0, no o_done; fresh start then completes normally.

Source files
------------

// File: rtl/RgbdVoConfigPk.sv
// -----------------------------------------------------------------------------
// RgbdVoConfigPk
// Shared fixed-point configuration for the RGB-D visual-odometry pose blocks.
//   POSE_BW  : width of one pose word (signed)
//   MUL      : fractional bits of the pose fixed-point format (1.0 = ONE)
//   ONE      : fixed-point 1.0
// Also holds the issue schedule of the pose inversion (which pose words feed
// the shared multiplier on each issue step, and which accumulator receives
// the product) and the fixed part of the inversion latency.
// -----------------------------------------------------------------------------
package RgbdVoConfigPk;

  localparam int POSE_BW = 32;
  localparam int MUL     = 24;

  localparam logic signed [POSE_BW-1:0] ONE =
    {{(POSE_BW-MUL-1){1'b0}}, 1'b1, {MUL{1'b0}}};

  // Derived datapath widths: full product, scaled product, accumulator.
  localparam int PROD_BW = 2 * POSE_BW;
  localparam int SCL_BW  = PROD_BW - MUL;
  localparam int ACC_BW  = SCL_BW + 2;

  // Inversion schedule: 9 multiplies, then fixed overhead of 11 cycles on
  // top of the multiplier pipeline depth (issue, shift reg, accumulate, output).
  localparam int N_ISSUE  = 9;
  localparam int LAT_BASE = 11;
  localparam int CNT_W    = 6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Rotation operand of issue step k: column r of R, walked down its rows.
  function automatic logic [3:0] issue_a(input logic [CNT_W-1:0] k);
    case (k)
      6'd0:    issue_a = 4'd0;
      6'd1:    issue_a = 4'd4;
      6'd2:    issue_a = 4'd8;
      6'd3:    issue_a = 4'd1;
      6'd4:    issue_a = 4'd5;
      6'd5:    issue_a = 4'd9;
      6'd6:    issue_a = 4'd2;
      6'd7:    issue_a = 4'd6;
      6'd8:    issue_a = 4'd10;
      default: issue_a = 4'd0;
    endcase
  endfunction

  // Translation operand of issue step k: t0, t1, t2 in turn.
  function automatic logic [3:0] issue_b(input logic [CNT_W-1:0] k);
    case (k)
      6'd0, 6'd3, 6'd6: issue_b = 4'd3;
      6'd1, 6'd4, 6'd7: issue_b = 4'd7;
      6'd2, 6'd5, 6'd8: issue_b = 4'd11;
      default:          issue_b = 4'd3;
    endcase
  endfunction

  // Accumulator (output translation row) targeted by issue step k.
  function automatic logic [1:0] issue_sel(input logic [CNT_W-1:0] k);
    case (k)
      6'd0, 6'd1, 6'd2: issue_sel = 2'd0;
      6'd3, 6'd4, 6'd5: issue_sel = 2'd1;
      6'd6, 6'd7, 6'd8: issue_sel = 2'd2;
      default:          issue_sel = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pose_mac.sv
// -----------------------------------------------------------------------------
// pose_mac
// Time-shared signed multiply / fixed-point rescale / accumulate for the pose
// inversion. Each valid operand pair is multiplied through a MUL_STAGES deep
// pipeline, the product is shifted right by MUL (arithmetic), registered, and
// added into one of three accumulators chosen by i_sel.
// Build option: INVERT_POSE_ROUND_EN adds 2^(MUL-1) before the shift (round
// half up); otherwise the shift truncates toward negative infinity.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : zero all three accumulators (new operation)
//   i_vld, i_sel   : operand pair valid, target accumulator 0..2
//   i_a, i_b       : signed operands
//   o_acc[3]       : low POSE_BW bits of each accumulator
// -----------------------------------------------------------------------------
module pose_mac
  import RgbdVoConfigPk::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clr,
  input  logic                      i_vld,
  input  logic [1:0]                i_sel,
  input  logic signed [POSE_BW-1:0] i_a,
  input  logic signed [POSE_BW-1:0] i_b,
  output logic [POSE_BW-1:0]        o_acc [3]
);

`ifdef INVERT_POSE_ROUND_EN
  localparam logic [PROD_BW-1:0] RND_C =
    {{(PROD_BW-MUL){1'b0}}, 1'b1, {(MUL-1){1'b0}}};
`else
  localparam logic [PROD_BW-1:0] RND_C = {PROD_BW{1'b0}};
`endif

  logic [PROD_BW-1:0] prod_s;
  logic [PROD_BW-1:0] prod_q [MUL_STAGES];
  logic               vld_q  [MUL_STAGES];
  logic [1:0]         sel_q  [MUL_STAGES];
  logic [SCL_BW-1:0]  scl_d;
  logic [SCL_BW-1:0]  scl_q;
  logic               scl_vld_q;
  logic [1:0]         scl_sel_q;
  logic [ACC_BW-1:0]  acc_q  [3];

  // Full-width signed product; size casts sign-extend the signed operands.
  always_comb begin
    prod_s = PROD_BW'(i_a) * PROD_BW'(i_b);
  end

  // Rounding offset then arithmetic shift; the kept bits [PROD_BW-1:MUL]
  // are the same whether the shift is logical or arithmetic.
  always_comb begin
    scl_d = SCL_BW'((prod_q[MUL_STAGES-1] + RND_C) >> MUL);
  end

  // Multiplier pipeline with its valid/select tags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < MUL_STAGES; s++) begin
        prod_q[s] <= {PROD_BW{1'b0}};
        vld_q[s]  <= 1'b0;
        sel_q[s]  <= 2'd0;
      end
    end else begin
      prod_q[0] <= prod_s;
      vld_q[0]  <= i_vld;
      sel_q[0]  <= i_sel;
      for (int s = 1; s < MUL_STAGES; s++) begin
        prod_q[s] <= prod_q[s-1];
        vld_q[s]  <= vld_q[s-1];
        sel_q[s]  <= sel_q[s-1];
      end
    end
  end

  // Scaled-product register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_q     <= {SCL_BW{1'b0}};
      scl_vld_q <= 1'b0;
      scl_sel_q <= 2'd0;
    end else begin
      scl_q     <= scl_d;
      scl_vld_q <= vld_q[MUL_STAGES-1];
      scl_sel_q <= sel_q[MUL_STAGES-1];
    end
  end

  // Accumulators; two guard bits above the scaled product absorb three adds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 3; i++) acc_q[i] <= {ACC_BW{1'b0}};
    end else if (i_clr) begin
      for (int i = 0; i < 3; i++) acc_q[i] <= {ACC_BW{1'b0}};
    end else if (scl_vld_q) begin
      for (int i = 0; i < 3; i++) begin
        if (scl_sel_q == 2'(i)) begin
          acc_q[i] <= acc_q[i] + {{2{scl_q[SCL_BW-1]}}, scl_q};
        end
      end
    end
  end

  // Only the low word is needed: negation mod 2^POSE_BW uses only those bits.
  always_comb begin
    for (int i = 0; i < 3; i++) o_acc[i] = acc_q[i][POSE_BW-1:0];
  end

endmodule

// File: rtl/invert_pose.sv
// -----------------------------------------------------------------------------
// invert_pose
// Inverts a rigid 3x4 pose [R|t] (row-major, fixed point with MUL fractional
// bits) into [R^T | -R^T t]. The rotation part is a transpose; the three
// translation terms use 9 multiplies issued one per cycle through the shared
// pose_mac. Result appears 11+MUL_STAGES cycles after an accepted start, with
// a one-cycle o_done pulse, and is held until the next completion.
// Build option: INVERT_POSE_ROUND_EN selects round-half-up product scaling
// (inside pose_mac); latency is the same either way.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : start request (accepted when idle or in the o_done cycle)
//   i_pose[12]     : input pose, captured on the accepted start edge
//   o_busy         : operation in flight (through the o_done cycle)
//   o_done         : single-cycle completion pulse
//   o_pose[12]     : inverted pose
// -----------------------------------------------------------------------------
module invert_pose
  import RgbdVoConfigPk::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic signed [POSE_BW-1:0] i_pose [12],
  output logic                      o_busy,
  output logic                      o_done,
  output logic signed [POSE_BW-1:0] o_pose [12]
);

  localparam int LAT = LAT_BASE + MUL_STAGES;
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(LAT - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic                      accept_s;
  logic signed [POSE_BW-1:0] pose_q [12];
  logic signed [POSE_BW-1:0] out_q  [12];
  logic signed [POSE_BW-1:0] out_d  [12];
  logic                      mac_vld_s;
  logic [1:0]                mac_sel_s;
  logic signed [POSE_BW-1:0] mac_a_s, mac_b_s;
  logic [POSE_BW-1:0]        acc_s  [3];

  // Next-state logic. cnt_q counts cycles since the accepted start edge; in
  // the o_done cycle a new start is taken directly without passing IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          accept_s = 1'b1;
          state_d  = ST_BUSY;
          cnt_d    = {CNT_W{1'b0}};
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done_q) begin
          cnt_d = {CNT_W{1'b0}};
          if (i_start) begin
            accept_s = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            state_d  = ST_IDLE;
          end
        end else begin
          cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          done_d = (cnt_q == DONE_CNT);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and done registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Input pose capture on the accepted start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 12; i++) pose_q[i] <= {POSE_BW{1'b0}};
    end else if (accept_s) begin
      pose_q <= i_pose;
    end
  end

  // Operand mux: step cnt_q of the schedule during the first 9 busy cycles.
  always_comb begin
    mac_vld_s = (state_q == ST_BUSY) && !done_q && (cnt_q < CNT_W'(N_ISSUE));
    mac_sel_s = issue_sel(cnt_q);
    mac_a_s   = pose_q[issue_a(cnt_q)];
    mac_b_s   = pose_q[issue_b(cnt_q)];
  end

  pose_mac #(
    .MUL_STAGES (MUL_STAGES)
  ) u_pose_mac (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (accept_s),
    .i_vld   (mac_vld_s),
    .i_sel   (mac_sel_s),
    .i_a     (mac_a_s),
    .i_b     (mac_b_s),
    .o_acc   (acc_s)
  );

  // Output words: all 12 load together on completion, else hold.
  always_comb begin
    out_d = out_q;
    if (done_d) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) out_d[r*4+c] = pose_q[c*4+r];
        out_d[r*4+3] = {POSE_BW{1'b0}} - acc_s[r];
      end
    end else begin
      out_d = out_q;
    end
  end

  // Output pose register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 12; i++) out_q[i] <= {POSE_BW{1'b0}};
    end else begin
      out_q <= out_d;
    end
  end

  assign o_busy = (state_q == ST_BUSY);
  assign o_done = done_q;
  assign o_pose = out_q;

endmodule
